mmc_dat_rx: RTL and testbench
=============================

Name: mmc_dat_rx

Overview:
- Parametrised MMC/SD data-bus block receiver for the mmc_controller datapath.
- Runtime-selectable 1/4/8-bit bus width and a parametrised block length.
- Per-line CRC16 check, start-bit timeout and end-bit check.
- Received bytes are buffered in a first-word-fall-through FIFO read by the Wishbone register side; a stall request pauses the MMC clock generator before the FIFO can overflow.

Parameters:
- BLOCK_BYTES, 512: data bytes per block (≥1).
- FIFO_DEPTH, 16: FIFO entries; power of two, ≥4.
- TIMEOUT_W, 16: start-bit timeout counter width; timeout = 2^TIMEOUT_W-1 samples.

Ports:
- wb_clk_i  in  1  system clock; sole clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- mmc_clk_en  in  1  one-cycle pulse, coincident with mmc_clk rising edge; the sample strobe.
- mmc_dat_i  in  8  MMC data lines.
- bus_width  in  2  00=1-bit (dat[0]), 01=4-bit (dat[3:0]), 10/11=8-bit.
- rx_start  in  1  one-cycle pulse arming reception of one block.
- rx_abort  in  1  one-cycle pulse; abandon the current block.
- rx_busy  out  1  high from the cycle after an accepted rx_start until done/abort/error.
- mmc_clk_stall  out  1  high while FIFO free slots ≤1.
- fifo_rd  in  1  pop strobe.
- fifo_dat  out  8  head of FIFO (fall-through).
- fifo_empty  out  1  FIFO empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- rx_done  out  1  one-cycle pulse at block end (success or error).
- crc_err  out  1  sticky; CRC mismatch on any used line.
- endbit_err  out  1  sticky; end bit not 1 on every used line.
- timeout_err  out  1  sticky; no start bit within the timeout.
- overflow_err  out  1  sticky; byte dropped because the FIFO was full.

Behaviour:
- Reset values: every output 0 except fifo_empty=1. FIFO flushed, FSM in IDLE. Reset mid-block discards the partial block with no rx_done.
- Actions happen only in wb_clk_i cycles with mmc_clk_en=1, except rx_start, rx_abort and FIFO ops.
- IDLE: rx_start latches bus_width, clears the four error flags, clears the timeout counter → WAIT_START. rx_start while busy is ignored. The FIFO is never cleared by rx_start.
- WAIT_START: a sample with all used lines 0 is the start bit → DATA. Otherwise the timeout counter increments; when it reaches all-ones: timeout_err=1, rx_done pulse → IDLE.
- DATA, bit order MSB-first:
  - 1-bit: 8 samples per byte, first sample = bit7.
  - 4-bit: 2 samples per byte, first sample = bits[7:4]; dat[3] is the nibble MSB.
  - 8-bit: 1 sample per byte = dat[7:0].
  - The completed byte is pushed the cycle after its last sample.
  - After BLOCK_BYTES bytes → CRC.
- CRC: one CRC16 generator per used line. Polynomial x^16+x^12+x^5+1, init 0, computed over that line's data bits only. Exactly 16 samples per line, MSB first; the received value is compared to the computed value. Any mismatch sets crc_err. → END.
- END: one sample; any used line 0 sets endbit_err. rx_done pulses the following cycle → IDLE.
- rx_abort in any non-IDLE state: → IDLE next cycle, no rx_done, error flags unchanged, FIFO contents kept.
- FIFO:
  - Push when a byte completes. If full with no simultaneous pop: byte dropped, overflow_err=1.
  - Simultaneous push+pop when full: both succeed, level unchanged.
  - fifo_rd while empty: ignored.
  - fifo_level wraps never; pointers wrap modulo FIFO_DEPTH.
- mmc_clk_stall is combinational from fifo_level (level ≥ FIFO_DEPTH-1). The clock generator suppresses mmc_clk_en while it is high.
- Unused data lines are ignored in every state.

Test Plan:
- 8-bit, BLOCK_BYTES=512: start on all lines at sample 9, bytes 0x00..0xFF twice, correct per-line CRCs, end bit 0xFF → 512 bytes read out in order, rx_done once, all error flags 0.
- 4-bit: nibble stream 0,1,…,F repeating, correct CRCs → bytes 0x01,0x23,…,0xEF repeating; no errors.
- 1-bit: byte 0xA5 pattern with CRC bit 3 inverted on dat[0] → data read intact, crc_err=1, rx_done pulses.
- WAIT_START with lines held 0xFF, TIMEOUT_W=4 → timeout_err=1 and rx_done after 15 samples, rx_busy=0, FIFO empty.
- FIFO_DEPTH=4, no fifo_rd: mmc_clk_stall asserts at level 3. Force one extra mmc_clk_en → 4th byte stored, 5th dropped, overflow_err=1.
- Assert wb_rst_i at byte 100 → outputs at reset values immediately, fifo_empty=1; a new rx_start then receives a clean block.

Source files
------------

// File: rtl/mmc_dat_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : mmc_dat_rx_if
// Brief    : Sample-side and FIFO-side signals of the MMC data-block receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface mmc_dat_rx_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int c_LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic               mmc_clk_en;
    logic [7:0]         mmc_dat_i;
    logic [1:0]         bus_width;
    logic               rx_start;
    logic               rx_abort;
    logic               rx_busy;
    logic               mmc_clk_stall;
    logic               fifo_rd;
    logic [7:0]         fifo_dat;
    logic               fifo_empty;
    logic [c_LVL_W-1:0] fifo_level;
    logic               rx_done;
    logic               crc_err;
    logic               endbit_err;
    logic               timeout_err;
    logic               overflow_err;

    modport master (
        output mmc_clk_en, mmc_dat_i, bus_width, rx_start, rx_abort, fifo_rd,
        input  rx_busy, mmc_clk_stall, fifo_dat, fifo_empty, fifo_level,
               rx_done, crc_err, endbit_err, timeout_err, overflow_err
    );

    modport slave (
        input  mmc_clk_en, mmc_dat_i, bus_width, rx_start, rx_abort, fifo_rd,
        output rx_busy, mmc_clk_stall, fifo_dat, fifo_empty, fifo_level,
               rx_done, crc_err, endbit_err, timeout_err, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/mmc_dat_rx.sv
`default_nettype none
// ============================================================================
// Module   : mmc_dat_rx
// Brief    : MMC/SD data-bus block receiver, 1/4/8-bit, per-line CRC16, FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module mmc_dat_rx #(
    parameter int BLOCK_BYTES = 512,
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_W   = 16
) (
    input  wire logic    wb_clk_i,
    input  wire logic    wb_rst_i,
    mmc_dat_rx_if.slave  bus
);
    localparam int c_LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int c_PTR_W  = $clog2(FIFO_DEPTH);
    localparam int c_BCNT_W = $clog2(BLOCK_BYTES + 1);
    localparam logic [c_BCNT_W-1:0]  c_BCNT_LAST = c_BCNT_W'(BLOCK_BYTES - 1);
    localparam logic [TIMEOUT_W-1:0] c_TO_LAST   = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [c_LVL_W-1:0]   c_LVL_FULL  = c_LVL_W'(FIFO_DEPTH);
    localparam logic [c_LVL_W-1:0]   c_LVL_STALL = c_LVL_W'(FIFO_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_DATA = 3'd2,
        S_CRC  = 3'd3,
        S_END  = 3'd4
    } state_t;

    state_t                r_state;
    logic [1:0]            r_width;
    logic [7:0]            r_mask;
    logic [TIMEOUT_W-1:0]  r_to_cnt;
    logic [2:0]            r_sub;
    logic [c_BCNT_W-1:0]   r_bcnt;
    logic [3:0]            r_crc_cnt;
    logic [6:0]            r_shift;
    logic                  r_push;
    logic [7:0]            r_push_dat;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_crc_err;
    logic                  r_endbit_err;
    logic                  r_timeout_err;
    logic                  r_overflow_err;

    logic [7:0]            w_mask_sel;
    logic [7:0]            w_samp;
    logic [7:0]            w_byte_next;
    logic                  w_last;
    logic                  w_start_acc;
    logic                  w_active;
    logic                  w_crc_upd;
    logic                  w_rxcrc_shift;
    logic [7:0]            w_crc_bad;

    assign w_start_acc   = (r_state == S_IDLE) && bus.rx_start;
    assign w_active      = bus.mmc_clk_en && !bus.rx_abort && (r_state != S_IDLE);
    assign w_crc_upd     = w_active && (r_state == S_DATA);
    assign w_rxcrc_shift = w_active && (r_state == S_CRC);
    assign w_samp        = bus.mmc_dat_i & r_mask;

    always_comb begin
        w_mask_sel = 8'hFF;
        case (bus.bus_width)
            2'b00:   w_mask_sel = 8'h01;
            2'b01:   w_mask_sel = 8'h0F;
            default: w_mask_sel = 8'hFF;
        endcase
    end

    // Assemble the byte including the current sample, MSB first.
    always_comb begin
        w_byte_next = bus.mmc_dat_i;
        w_last      = 1'b1;
        case (r_width)
            2'b00: begin
                w_byte_next = {r_shift[6:0], bus.mmc_dat_i[0]};
                w_last      = (r_sub == 3'd7);
            end
            2'b01: begin
                w_byte_next = {r_shift[3:0], bus.mmc_dat_i[3:0]};
                w_last      = (r_sub == 3'd1);
            end
            default: begin
                w_byte_next = bus.mmc_dat_i;
                w_last      = 1'b1;
            end
        endcase
    end

    // One CRC16 generator and one received-CRC shifter per data line.
    for (genvar gi = 0; gi < 8; gi++) begin : g_line
        logic [15:0] r_crc;
        logic [15:0] r_rxcrc;
        logic        w_fb;

        assign w_fb = r_crc[15] ^ bus.mmc_dat_i[gi];

        always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
            if (wb_rst_i) begin
                r_crc   <= 16'h0000;
                r_rxcrc <= 16'h0000;
            end else if (w_start_acc) begin
                r_crc   <= 16'h0000;
                r_rxcrc <= 16'h0000;
            end else if (w_crc_upd) begin
                r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? 16'h1021 : 16'h0000);
            end else if (w_rxcrc_shift) begin
                r_rxcrc <= {r_rxcrc[14:0], bus.mmc_dat_i[gi]};
            end
        end

        assign w_crc_bad[gi] = r_mask[gi] && (r_rxcrc != r_crc);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state       <= S_IDLE;
            r_width       <= 2'b00;
            r_mask        <= 8'h00;
            r_to_cnt      <= '0;
            r_sub         <= 3'd0;
            r_bcnt        <= '0;
            r_crc_cnt     <= 4'd0;
            r_shift       <= 7'd0;
            r_push        <= 1'b0;
            r_push_dat    <= 8'h00;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_crc_err     <= 1'b0;
            r_endbit_err  <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_push <= 1'b0;
            if (r_state == S_IDLE) begin
                if (bus.rx_start) begin
                    r_width       <= bus.bus_width;
                    r_mask        <= w_mask_sel;
                    r_to_cnt      <= '0;
                    r_crc_err     <= 1'b0;
                    r_endbit_err  <= 1'b0;
                    r_timeout_err <= 1'b0;
                    r_busy        <= 1'b1;
                    r_state       <= S_WAIT;
                end
            end else if (bus.rx_abort) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
            end else if (bus.mmc_clk_en) begin
                case (r_state)
                    S_WAIT: begin
                        if (w_samp == 8'h00) begin
                            r_sub   <= 3'd0;
                            r_bcnt  <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
                            if (r_to_cnt == c_TO_LAST) begin
                                r_timeout_err <= 1'b1;
                                r_done        <= 1'b1;
                                r_busy        <= 1'b0;
                                r_state       <= S_IDLE;
                            end
                        end
                    end
                    S_DATA: begin
                        r_shift <= w_byte_next[6:0];
                        if (w_last) begin
                            r_sub      <= 3'd0;
                            r_push     <= 1'b1;
                            r_push_dat <= w_byte_next;
                            r_bcnt     <= r_bcnt + 1'b1;
                            if (r_bcnt == c_BCNT_LAST) begin
                                r_crc_cnt <= 4'd0;
                                r_state   <= S_CRC;
                            end
                        end else begin
                            r_sub <= r_sub + 3'd1;
                        end
                    end
                    S_CRC: begin
                        r_crc_cnt <= r_crc_cnt + 4'd1;
                        if (r_crc_cnt == 4'd15) begin
                            r_state <= S_END;
                        end
                    end
                    S_END: begin
                        // Received CRC shifters are complete by now; check both here.
                        if (|w_crc_bad) begin
                            r_crc_err <= 1'b1;
                        end
                        if (w_samp != r_mask) begin
                            r_endbit_err <= 1'b1;
                        end
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    logic [7:0]          r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]  r_wptr;
    logic [c_PTR_W-1:0]  r_rptr;
    logic [c_LVL_W-1:0]  r_level;
    logic                w_empty;
    logic                w_full;
    logic                w_pop;
    logic                w_wr;
    logic                w_drop;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_LVL_FULL);
    assign w_pop   = bus.fifo_rd && !w_empty;
    assign w_wr    = r_push && (!w_full || w_pop);
    assign w_drop  = r_push && w_full && !w_pop;

    always_ff @(posedge wb_clk_i) begin
        if (w_wr) begin
            r_mem[r_wptr] <= r_push_dat;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
            r_overflow_err <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow_err <= 1'b1;
            end else if (w_start_acc) begin
                r_overflow_err <= 1'b0;
            end
        end
    end

    assign bus.rx_busy       = r_busy;
    assign bus.rx_done       = r_done;
    assign bus.crc_err       = r_crc_err;
    assign bus.endbit_err    = r_endbit_err;
    assign bus.timeout_err   = r_timeout_err;
    assign bus.overflow_err  = r_overflow_err;
    assign bus.fifo_empty    = w_empty;
    assign bus.fifo_level    = r_level;
    assign bus.fifo_dat      = w_empty ? 8'h00 : r_mem[r_rptr];
    assign bus.mmc_clk_stall = (r_level >= c_LVL_STALL);

endmodule
`default_nettype wire

// File: tb/tb_mmc_dat_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmc_dat_rx
// Brief    : Scoreboard bench for mmc_dat_rx (8/4/1-bit blocks, timeout, overflow, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmc_dat_rx;
    localparam int c_BLOCK = 512;
    localparam int c_DEPTH = 4;
    localparam int c_TW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmc_dat_rx_if #(.FIFO_DEPTH(c_DEPTH)) bus ();

    mmc_dat_rx #(
        .BLOCK_BYTES (c_BLOCK),
        .FIFO_DEPTH  (c_DEPTH),
        .TIMEOUT_W   (c_TW)
    ) u_dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus)
    );

    int          n_chk = 0;
    int          n_bad = 0;
    int          done_cnt = 0;
    int          done_exp = 0;
    bit          rd_en = 1'b0;
    bit          force_en = 1'b0;
    logic [7:0]  exp_q [$];
    logic [15:0] mcrc [8];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    function automatic logic [7:0] msk(input logic [1:0] w);
        return (w == 2'b00) ? 8'h01 : (w == 2'b01) ? 8'h0F : 8'hFF;
    endfunction

    always @(negedge clk) if (bus.rx_done) done_cnt++;

    // FIFO reader: random-rate pops, each popped head compared to the scoreboard.
    initial begin
        bus.fifo_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (rd_en && !bus.fifo_empty && $urandom_range(0, 3) != 0) begin
                if (exp_q.size() == 0) chk("fifo_extra", exp_q.size(), 1);
                else                   chk("fifo_dat", bus.fifo_dat, exp_q.pop_front());
                bus.fifo_rd = 1'b1;
            end else begin
                bus.fifo_rd = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int w = 0;
        if (!force_en && $urandom_range(0, 3) == 0) @(negedge clk);
        while (bus.mmc_clk_stall && !force_en && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) chk("stall_stuck", bus.mmc_clk_stall, 0);
        bus.mmc_clk_en = 1'b1;
        bus.mmc_dat_i  = d;
        @(negedge clk);
        bus.mmc_clk_en = 1'b0;
        bus.mmc_dat_i  = 8'($urandom);
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) mcrc[i] = crc_step(mcrc[i], d[i]);
        send(d);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic [1:0] w, input bit keep);
        logic [7:0] r;
        if (keep) exp_q.push_back(b);
        case (w)
            2'b00: for (int k = 7; k >= 0; k--) begin
                r = 8'($urandom);
                send_data({r[7:1], b[k]});
            end
            2'b01: begin
                r = 8'($urandom);
                send_data({r[7:4], b[7:4]});
                r = 8'($urandom);
                send_data({r[7:4], b[3:0]});
            end
            default: send_data(b);
        endcase
    endtask

    task automatic start_rx(input logic [1:0] w);
        bus.bus_width = w;
        bus.rx_start  = 1'b1;
        @(negedge clk);
        bus.rx_start  = 1'b0;
        bus.bus_width = 2'($urandom);
        for (int i = 0; i < 8; i++) mcrc[i] = 16'h0000;
        chk("busy_after_start", bus.rx_busy, 1);
    endtask

    task automatic send_start(input logic [1:0] w);
        send(8'($urandom) & ~msk(w));
    endtask

    task automatic send_crc(input logic [1:0] w, input int flip_bit);
        logic [7:0] d;
        for (int b = 15; b >= 0; b--) begin
            d = 8'($urandom);
            for (int i = 0; i < 8; i++) if (msk(w)[i]) d[i] = mcrc[i][b];
            if (b == flip_bit) d[0] = ~d[0];
            send(d);
        end
    endtask

    task automatic send_end(input logic [1:0] w);
        send(8'($urandom) | msk(w));
    endtask

    task automatic wait_done(input string tag);
        int got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            if (bus.rx_done) got = 1;
            else @(negedge clk);
        end
        chk(tag, got, 1);
        done_exp++;
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        rd_en = 1'b1;
        while ((exp_q.size() != 0 || !bus.fifo_empty) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_q"}, exp_q.size(), 0);
        chk({tag, "_empty"}, bus.fifo_empty, 1);
        chk({tag, "_dones"}, done_cnt, done_exp);
    endtask

    task automatic run_block(input logic [1:0] w, input int mode, input int flip_bit);
        logic [7:0] b;
        send_start(w);
        for (int i = 0; i < c_BLOCK; i++) begin
            case (mode)
                0:       b = 8'(i);
                1:       b = {4'(2 * i), 4'(2 * i + 1)};
                2:       b = 8'hA5;
                default: b = 8'($urandom);
            endcase
            if (mode == 1 && i == 10) begin
                bus.bus_width = 2'b00;
                bus.rx_start  = 1'b1;
                @(negedge clk);
                bus.rx_start  = 1'b0;
            end
            send_byte(b, w, 1'b1);
        end
        send_crc(w, flip_bit);
        send_end(w);
    endtask

    initial begin
        bus.mmc_clk_en = 1'b0;
        bus.mmc_dat_i  = 8'h00;
        bus.bus_width  = 2'b00;
        bus.rx_start   = 1'b0;
        bus.rx_abort   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy",  bus.rx_busy, 0);
        chk("rst_stall", bus.mmc_clk_stall, 0);
        chk("rst_empty", bus.fifo_empty, 1);
        chk("rst_level", bus.fifo_level, 0);
        chk("rst_dat",   bus.fifo_dat, 0);
        chk("rst_done",  bus.rx_done, 0);
        chk("rst_errs",  {bus.crc_err, bus.endbit_err, bus.timeout_err, bus.overflow_err}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 8-bit block, start bit on the 9th sample
        rd_en = 1'b1;
        start_rx(2'b10);
        repeat (8) send(8'hFF);
        run_block(2'b10, 0, -1);
        wait_done("t8_done");
        chk("t8_errs", {bus.crc_err, bus.endbit_err, bus.timeout_err, bus.overflow_err}, 0);
        chk("t8_busy", bus.rx_busy, 0);
        drain("t8");

        // 4-bit block with an rx_start pulse mid-block that must be ignored
        start_rx(2'b01);
        run_block(2'b01, 1, -1);
        wait_done("t4_done");
        chk("t4_errs", {bus.crc_err, bus.endbit_err, bus.timeout_err, bus.overflow_err}, 0);
        drain("t4");

        // 1-bit block, CRC bit 3 inverted on dat[0]
        start_rx(2'b00);
        run_block(2'b00, 2, 3);
        wait_done("t1_done");
        chk("t1_errs", {bus.crc_err, bus.endbit_err, bus.timeout_err, bus.overflow_err}, 4'b1000);
        drain("t1");

        // start-bit timeout
        start_rx(2'b10);
        chk("to_crc_cleared", bus.crc_err, 0);
        repeat (14) send(8'hFF);
        chk("to_early_err",  bus.timeout_err, 0);
        chk("to_early_busy", bus.rx_busy, 1);
        send(8'hFF);
        chk("to_done",  bus.rx_done, 1);
        chk("to_err",   bus.timeout_err, 1);
        chk("to_busy",  bus.rx_busy, 0);
        chk("to_empty", bus.fifo_empty, 1);
        done_exp++;
        @(negedge clk);
        drain("to");

        // overflow with no reader, then abort keeps the FIFO contents
        rd_en = 1'b0;
        @(negedge clk);
        start_rx(2'b10);
        send_start(2'b10);
        send_byte(8'h11, 2'b10, 1'b1);
        @(negedge clk);
        send_byte(8'h22, 2'b10, 1'b1);
        @(negedge clk);
        chk("ov_lvl2",   bus.fifo_level, 2);
        chk("ov_stall2", bus.mmc_clk_stall, 0);
        send_byte(8'h33, 2'b10, 1'b1);
        @(negedge clk);
        chk("ov_lvl3",   bus.fifo_level, 3);
        chk("ov_stall3", bus.mmc_clk_stall, 1);
        force_en = 1'b1;
        send_byte(8'h44, 2'b10, 1'b1);
        @(negedge clk);
        chk("ov_lvl4",   bus.fifo_level, 4);
        chk("ov_noerr",  bus.overflow_err, 0);
        send_byte(8'h55, 2'b10, 1'b0);
        @(negedge clk);
        force_en = 1'b0;
        chk("ov_err",    bus.overflow_err, 1);
        chk("ov_lvl_keep", bus.fifo_level, 4);
        bus.rx_abort = 1'b1;
        @(negedge clk);
        bus.rx_abort = 1'b0;
        chk("ab_busy", bus.rx_busy, 0);
        repeat (3) @(negedge clk);
        chk("ab_err_kept", bus.overflow_err, 1);
        chk("ab_lvl_kept", bus.fifo_level, 4);
        drain("ab");

        // reset in the middle of a block
        start_rx(2'b10);
        send_start(2'b10);
        for (int i = 0; i < 100; i++) send_byte(8'($urandom), 2'b10, 1'b1);
        rd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", bus.rx_busy, 1);
        rst = 1'b1;
        #1;
        chk("mr_busy",  bus.rx_busy, 0);
        chk("mr_empty", bus.fifo_empty, 1);
        chk("mr_level", bus.fifo_level, 0);
        chk("mr_dat",   bus.fifo_dat, 0);
        chk("mr_stall", bus.mmc_clk_stall, 0);
        chk("mr_errs",  {bus.rx_done, bus.crc_err, bus.endbit_err, bus.timeout_err, bus.overflow_err}, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rd_en = 1'b1;
        start_rx(2'b10);
        run_block(2'b10, 3, -1);
        wait_done("mr_done");
        chk("mr2_errs", {bus.crc_err, bus.endbit_err, bus.timeout_err, bus.overflow_err}, 0);
        drain("mr2");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
